// File: rtl/add_arbiter.sv
// add_arbiter: shares one registered WIDTH-bit adder among N_REQ requesters.
// Requests are granted one at a time, round-robin from a rotating pointer.
// Each sum is returned with the winner's ID on one response channel that
// honours backpressure. Transactions pass through IDLE -> CALC -> RESP.
// Build option: define ADD_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// With that option the rotating pointer is ignored, and requester 0 can
// starve all the others.
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH:0]         rsp_sum,
  output logic [IDW-1:0]         rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_sum;

  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_idx;
  logic             w_found;
  logic             w_accept;
  logic             w_rsp_hs;

  // Winner search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
      w_idx = (IDW+1)'(k);
`else
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N_REQ)) begin
        w_idx = w_idx - (IDW+1)'(N_REQ);
      end
`endif
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Next-state logic and the handshake outputs for each state.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // The grant is combinational. It is suppressed while reset is held.
        if (w_found && !rst) begin
          req_ready[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = ST_CALC;
        end
      end
      ST_CALC: begin
        busy        = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register. Reset drops any in-flight transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, the registered add, and the pointer advance on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so a dropped transaction leaves sum/id at 0.
      r_ptr <= '0;
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= req_a[w_win*WIDTH +: WIDTH];
        r_b  <= req_b[w_win*WIDTH +: WIDTH];
        r_id <= w_win;
      end
      if (r_state == ST_CALC) begin
        r_sum <= {1'b0, r_a} + {1'b0, r_b};
      end
      if (w_rsp_hs) begin
        r_ptr <= (r_id == IDW'(N_REQ-1)) ? '0 : r_id + 1'b1;
      end
    end
  end

  assign rsp_sum = r_sum;
  assign rsp_id  = r_id;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_add_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [WIDTH:0]         rsp_sum;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_ready;
  logic                   busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  add_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int rid;
    int a;
    int b;
    int sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: scan upward from ptr modulo N_REQ.
  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
`ifdef ADD_ARB_FIXED_PRIO_EN
    ptr = 0;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (ptr + k) % N_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input int a, input int b);
    req_valid[i]              = v;
    req_a[i*WIDTH +: WIDTH]   = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH]   = WIDTH'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One lone request with full cycle-by-cycle timing checks.
  task automatic do_single(input int rid, input int a, input int b, input int exp_sum);
    @(negedge clk);
    set_req(rid, 1'b1, a, b);
    rsp_ready = 1'b1;
    #1;
    check("single_ready", req_ready, onehot(rid));
    check("single_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    req_valid[rid] = 1'b0;
    @(negedge clk);
    #1;
    check("calc_rsp_valid", rsp_valid, 0);
    check("calc_busy", busy, 1);
    check("calc_ready", req_ready, 0);
    @(negedge clk);
    #1;
    check("resp_valid", rsp_valid, 1);
    check("resp_sum", rsp_sum, exp_sum);
    check("resp_id", rsp_id, rid);
    check("resp_busy", busy, 1);
    @(negedge clk);
    #1;
    check("after_rsp_valid", rsp_valid, 0);
    check("after_busy", busy, 0);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  // Gather n responses (rsp_ready held high), checking id, sum and 3-cycle spacing.
  task automatic collect(input string tag, input int n, input int ids[8], input int sums[8]);
    int got    = 0;
    int prev   = -1;
    int budget = 0;
    while (got < n && budget < 60) begin
      @(negedge clk);
      #1;
      budget++;
      if (rsp_valid) begin
        check({tag, "_id"}, rsp_id, ids[got]);
        check({tag, "_sum"}, rsp_sum, sums[got]);
        if (prev >= 0) check({tag, "_gap"}, cyc - prev, 3);
        prev = cyc;
        got++;
      end
    end
    if (got < n) check({tag, "_timeout"}, got, n);
  endtask

  initial begin
    vec_t tbl[5];
    int ids[8];
    int sums[8];

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state: no grant while rst is high, even with every requester valid.
    #2;
    req_valid = '1;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;

    // Directed single-request vectors, including the carry-out case.
    tbl[0] = '{rid: 0, a: 5,  b: 5,  sum: 10};
    tbl[1] = '{rid: 2, a: 15, b: 15, sum: 30};
    tbl[2] = '{rid: 1, a: 0,  b: 0,  sum: 0};
    tbl[3] = '{rid: 3, a: 15, b: 1,  sum: 16};
    tbl[4] = '{rid: 3, a: 7,  b: 8,  sum: 15};
    for (int i = 0; i < 5; i++) begin
      do_single(tbl[i].rid, tbl[i].a, tbl[i].b, tbl[i].sum);
    end

    // All four requesters valid continuously with rsp_ready held high.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i + 1, i + 2);
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
      ids[k] = 0;
`else
      ids[k] = k % N_REQ;
`endif
      sums[k] = 2 * ids[k] + 3;
    end
    collect("rr", 8, ids, sums);
    req_valid = '0;

    // Backpressure: hold the response for 5 cycles, then hand over to requester 1.
    do_reset();
    set_req(0, 1'b1, 9, 3);
    set_req(1, 1'b1, 4, 4);
    rsp_ready = 1'b0;
    #1;
    check("bp_grant0", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_rsp("bp_first", 5);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) begin
        @(negedge clk);
        #1;
      end
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 12);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_after_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0010);
    wait_rsp("bp_second", 5);
    check("bp_second_id", rsp_id, 1);
    check("bp_second_sum", rsp_sum, 8);
    req_valid = '0;

    // Reset in CALC: pointer first moved to 3, then reset must bring it back to 0.
    do_reset();
    do_single(2, 1, 1, 2);
    @(negedge clk);
    set_req(1, 1'b1, 6, 7);
    #1;
    check("rc_grant1", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check("rc_rsp_valid", rsp_valid, 0);
    check("rc_busy", busy, 0);
    check("rc_ready", req_ready, 0);
    #1;
    rst = 1'b0;
    set_req(1, 1'b1, 6, 7);
    set_req(3, 1'b1, 2, 9);
    #1;
    check("rc_ptr_zero", req_ready, 4'b0010);
    req_valid = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      check("rc_dropped", rsp_valid, 0);
      check("rc_idle_busy", busy, 0);
    end
    do_single(3, 2, 9, 11);

    // Wrap: only requesters 0 and 3 valid, starting with ptr=0.
    do_reset();
    set_req(0, 1'b1, 1, 2);
    set_req(3, 1'b1, 5, 6);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
      ids[k] = 0;
`else
      ids[k] = (k % 2 == 0) ? 0 : 3;
`endif
      sums[k] = (ids[k] == 0) ? 3 : 11;
    end
    collect("wrap", 4, ids, sums);
    req_valid = '0;

    // Randomized run against a transaction-level model.
    do_reset();
    begin
      logic [N_REQ-1:0] acc_last;
      int m_ptr  = 0;
      int m_busy = 0;
      int m_age  = 0;
      int m_id   = 0;
      int m_sum  = 0;
      int n_rsp  = 0;
      int win;
      acc_last = '0;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
          if (acc_last[i]) begin
            if ($urandom_range(1) == 1)
              set_req(i, 1'b1, int'($urandom_range(15)), int'($urandom_range(15)));
            else
              req_valid[i] = 1'b0;
          end else if (!req_valid[i] && $urandom_range(2) == 0) begin
            set_req(i, 1'b1, int'($urandom_range(15)), int'($urandom_range(15)));
          end
        end
        rsp_ready = ($urandom_range(3) != 0);
        #1;
        win = (m_busy != 0) ? -1 : rr_pick(req_valid, m_ptr);
        check("rnd_ready", req_ready, (win < 0) ? '0 : onehot(win));
        check("rnd_busy", busy, m_busy);
        check("rnd_rsp_valid", rsp_valid, (m_busy != 0 && m_age == 2) ? 1 : 0);
        if (m_busy != 0 && m_age == 2) begin
          check("rnd_sum", rsp_sum, m_sum);
          check("rnd_id", rsp_id, m_id);
        end
        acc_last = '0;
        if (m_busy != 0) begin
          if (m_age == 2) begin
            if (rsp_ready) begin
              m_busy = 0;
              m_ptr  = (m_id + 1) % N_REQ;
              n_rsp++;
            end
          end else begin
            m_age++;
          end
        end else if (win >= 0) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = win;
          m_sum  = int'(req_a[win*WIDTH +: WIDTH]) + int'(req_b[win*WIDTH +: WIDTH]);
          acc_last[win] = 1'b1;
        end
      end
      check("rnd_progress", (n_rsp > 100) ? 1 : 0, 1);
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one registered WIDTH-bit adder among N_REQ requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester at a time in round-robin order, computes the sum, and returns it with the winner's ID on a single response channel under backpressure. It sits between the stimulus-side task drivers and the shared adder datapath, and it is the only block that sequences that adder.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- WIDTH, 4: operand width; the sum is WIDTH+1 bits.
- IDW, $clog2(N_REQ): width of the ID field (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i = requester i has an operand pair.
- req_a  in  N_REQ*WIDTH  requester i operand A at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  requester i operand B, same packing.
- req_ready  out  N_REQ  one-hot or zero; bit i = operands of requester i are accepted this cycle.
- rsp_valid  out  1  response present.
- rsp_sum  out  WIDTH+1  a+b, zero-extended, no truncation.
- rsp_id  out  IDW  index of the requester that owns rsp_sum.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in CALC or RESP.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - The winner is the first requester with req_valid set, searching upward from ptr and wrapping modulo N_REQ.
  - req_ready[winner] is combinational in IDLE; all other bits are 0.
  - If no requester is valid, req_ready is 0 and the FSM stays in IDLE.
  - On a clk edge where req_valid[w] and req_ready[w] are both high:
    - latch a_q, b_q and id_q = w;
    - go to CALC.
- CALC: sum_q <= a_q + b_q, computed at WIDTH+1 bits. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_sum = sum_q; rsp_id = id_q.
  - On the edge with rsp_ready = 1: set ptr <= (id_q+1) mod N_REQ and go to IDLE.
- req_ready is 0 in CALC and RESP. Only one transaction is in flight at any time.
- Requester rule: once req_valid[i] rises, it holds, with stable operands, until req_ready[i] is seen. The block does not need to tolerate violations of this rule.
- Response stability: rsp_sum and rsp_id stay constant while rsp_valid=1 and rsp_ready=0.
- Reset:
  - rst asserted at any time, including mid-CALC or mid-RESP, takes effect immediately (asynchronously).
  - It sets state=IDLE, ptr=0, a_q=b_q=sum_q=id_q=0.
  - Any in-flight transaction is dropped with no response.
- Reset values of outputs: req_ready=0 (while rst is high), rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.

## Timing
- Acceptance edge is k.
- CALC is the cycle after edge k; rsp_valid rises after edge k+1 (CALC→RESP).
- Latency from acceptance edge to first rsp_valid cycle is 2 cycles.
- If rsp_ready is held at 1, throughput is one transaction per 3 cycles (accept, CALC, RESP), and the next grant is visible the cycle after the response handshake.
- Response handshake and a new request arriving in the same cycle: the request is not seen until IDLE. There is no bypass.
- ptr wraps from N_REQ-1 to 0.
- The winner's req_valid may fall on the handshake edge itself; the block must allow this.

## Configuration
- ADD_ARB_FIXED_PRIO_EN:
  - Defined: the winner is the lowest-index valid requester, ptr is unused, and requester 0 can starve all others.
  - Undefined (default): round-robin exactly as specified above.
- All other behaviour and all timing are identical in both builds.

## Test plan
- Single request: requester 0 sends a=5, b=5 → accepted at edge k; rsp_valid after edge k+1 with rsp_sum=10, rsp_id=0; busy=1 across CALC and RESP.
- Carry: requester 2 sends a=15, b=15 → rsp_sum=30 (5'b11110), rsp_id=2; no truncation.
- All four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,…; each response arrives 3 cycles after the previous one.
  - With ADD_ARB_FIXED_PRIO_EN, the same stimulus gives rsp_id=0 every time.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_sum and rsp_id are held constant; req_ready=0 throughout; the grant goes to the next requester after the handshake.
- Reset in CALC: requester 1 accepted, rst pulsed during CALC → rsp_valid=0, busy=0 and ptr=0 immediately; a later single request from requester 3 completes normally with rsp_id=3.
- Wrap: only requesters 3 and 0 valid, starting from ptr=0 → order 0,3,0,3, showing ptr wrapping from 3 to 0.
